// File: rtl/thread_dispatch_pkg.sv
// Shared constants and types for the issue stage and its EX-side consumers.
package thread_dispatch_pkg;

    localparam int NUM_THREADS = 4;
    localparam int NUM_ALUS    = 3;
    localparam int TID_W       = 3;
    localparam int PTR_W       = 2;   // log2(NUM_THREADS); NUM_THREADS is a power of two
    localparam int FLUSH_W     = 3;

    localparam logic [TID_W-1:0]   IDLE_TID        = 3'd4;
    localparam logic [TID_W-1:0]   NUM_THREADS_TID = 3'd4;
    localparam logic [FLUSH_W-1:0] FLUSH_CYCLES    = 3'd2;
    localparam logic [31:0]        NOP_INST        = 32'h0000_0013;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [31:0]      inst;
    } dispatch_slot_t;

    // A tid names a real hardware thread (as opposed to the idle marker or junk).
    function automatic logic tid_is_real(input logic [TID_W-1:0] tid);
        return (tid < NUM_THREADS_TID);
    endfunction

endpackage

// File: rtl/thread_dispatch_if.sv
// Bundle between decode/EX and the dispatcher; slave is the dispatcher side.
interface thread_dispatch_if;
    import thread_dispatch_pkg::*;

    logic [NUM_THREADS-1:0]             thread_valid_i;
    logic [NUM_THREADS-1:0][31:0]       thread_inst_i;
    logic [NUM_THREADS-1:0]             thread_stall_i;
    logic                               ex_ready_i;
    logic [NUM_ALUS-1:0]                jump_en_i;
    logic [NUM_ALUS-1:0][TID_W-1:0]     jump_tid_i;
    logic [NUM_ALUS-1:0][TID_W-1:0]     dispatch_threads_o;
    logic [NUM_ALUS-1:0][31:0]          dispatch_inst_o;
    logic [NUM_THREADS-1:0]             issue_ack_o;

    modport master (
        output thread_valid_i, thread_inst_i, thread_stall_i,
        output ex_ready_i, jump_en_i, jump_tid_i,
        input  dispatch_threads_o, dispatch_inst_o, issue_ack_o
    );

    modport slave (
        input  thread_valid_i, thread_inst_i, thread_stall_i,
        input  ex_ready_i, jump_en_i, jump_tid_i,
        output dispatch_threads_o, dispatch_inst_o, issue_ack_o
    );

endinterface

// File: rtl/thread_dispatch_rr_multi_pick.sv
// Combinational round-robin picker: fills slots in scan order starting at rr_ptr.
module rr_multi_pick
    import thread_dispatch_pkg::*;
(
    input  logic [NUM_THREADS-1:0]          elig_i,
    input  logic [PTR_W-1:0]                rr_ptr_i,
    output logic [NUM_ALUS-1:0][TID_W-1:0]  slot_tid_o,
    output logic [NUM_ALUS-1:0]             slot_valid_o,
    output logic [PTR_W-1:0]                rr_ptr_next_o
);

    logic [PTR_W-1:0] cand_s;
    logic [1:0]       cnt_s;

    // Walk one full wrap from rr_ptr; the pointer add wraps naturally at NUM_THREADS.
    always_comb begin
        slot_tid_o    = {NUM_ALUS{IDLE_TID}};
        slot_valid_o  = '0;
        rr_ptr_next_o = rr_ptr_i;
        cnt_s         = 2'd0;
        cand_s        = rr_ptr_i;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cand_s = rr_ptr_i + PTR_W'(i);
            if (elig_i[cand_s] && (cnt_s < 2'(NUM_ALUS))) begin
                slot_tid_o[cnt_s]   = TID_W'(cand_s);
                slot_valid_o[cnt_s] = 1'b1;
                rr_ptr_next_o       = cand_s + PTR_W'(1);
                cnt_s               = cnt_s + 2'd1;
            end else begin
                // Ineligible thread or all slots taken: nothing to fill.
                cnt_s = cnt_s;
            end
        end
    end

endmodule

// File: rtl/thread_dispatch.sv
// Issue stage: picks up to NUM_ALUS ready threads per cycle and registers the bundle.
module thread_dispatch
    import thread_dispatch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    thread_dispatch_if.slave    bus
);

    logic [NUM_THREADS-1:0][FLUSH_W-1:0] flush_q;
    logic [NUM_THREADS-1:0]              jump_hit_s;
    logic [NUM_THREADS-1:0]              elig_s;
    logic [NUM_ALUS-1:0][TID_W-1:0]      pick_tid_s;
    logic [NUM_ALUS-1:0]                 pick_valid_s;
    logic [PTR_W-1:0]                    rr_next_s;
    logic [PTR_W-1:0]                    rr_q;
    dispatch_slot_t [NUM_ALUS-1:0]       slot_d;
    dispatch_slot_t [NUM_ALUS-1:0]       slot_q;
    logic [NUM_THREADS-1:0]              ack_d;
    logic [NUM_THREADS-1:0]              ack_q;

    // A taken jump in any EX slot blocks its thread this very cycle; bogus tids are ignored.
    always_comb begin
        jump_hit_s = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            for (int k = 0; k < NUM_ALUS; k++) begin
                jump_hit_s[t] = jump_hit_s[t]
                              | (bus.jump_en_i[k]
                                 & tid_is_real(bus.jump_tid_i[k])
                                 & (bus.jump_tid_i[k] == TID_W'(t)));
            end
        end
    end

    // Thread is issuable when it has work, no hazard, and no pending flush.
    always_comb begin
        elig_s = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            elig_s[t] = bus.thread_valid_i[t] & ~bus.thread_stall_i[t]
                      & (flush_q[t] == 3'd0) & ~jump_hit_s[t];
        end
    end

    rr_multi_pick u_pick (
        .elig_i        (elig_s),
        .rr_ptr_i      (rr_q),
        .slot_tid_o    (pick_tid_s),
        .slot_valid_o  (pick_valid_s),
        .rr_ptr_next_o (rr_next_s)
    );

    // Build the candidate bundle and its per-thread acknowledge vector.
    always_comb begin
        slot_d = '0;
        ack_d  = '0;
        for (int s = 0; s < NUM_ALUS; s++) begin
            if (pick_valid_s[s]) begin
                slot_d[s].tid  = pick_tid_s[s];
                slot_d[s].inst = bus.thread_inst_i[pick_tid_s[s][PTR_W-1:0]];
            end else begin
                slot_d[s].tid  = IDLE_TID;
                slot_d[s].inst = NOP_INST;
            end
        end
        for (int t = 0; t < NUM_THREADS; t++) begin
            for (int s = 0; s < NUM_ALUS; s++) begin
                ack_d[t] = ack_d[t] | (pick_valid_s[s] & (pick_tid_s[s] == TID_W'(t)));
            end
        end
    end

    // Flush countdown runs every cycle, independent of EX back-pressure; a jump reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (jump_hit_s[t]) begin
                    flush_q[t] <= FLUSH_CYCLES;
                end else if (flush_q[t] != 3'd0) begin
                    flush_q[t] <= flush_q[t] - 3'd1;
                end else begin
                    flush_q[t] <= flush_q[t];
                end
            end
        end
    end

    // Commit a new bundle only when EX takes it; otherwise hold slots and drop acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_ALUS; s++) begin
                slot_q[s].tid  <= IDLE_TID;
                slot_q[s].inst <= NOP_INST;
            end
            ack_q <= '0;
            rr_q  <= '0;
        end else if (bus.ex_ready_i) begin
            slot_q <= slot_d;
            ack_q  <= ack_d;
            rr_q   <= rr_next_s;
        end else begin
            slot_q <= slot_q;
            ack_q  <= '0;
            rr_q   <= rr_q;
        end
    end

    for (genvar s = 0; s < NUM_ALUS; s++) begin : g_out
        assign bus.dispatch_threads_o[s] = slot_q[s].tid;
        assign bus.dispatch_inst_o[s]    = slot_q[s].inst;
    end
    assign bus.issue_ack_o = ack_q;

endmodule

// File: tb/tb_thread_dispatch.sv
// Directed plus randomized bench with a queue-based reference model of the dispatcher.
module tb_thread_dispatch;
    import thread_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    thread_dispatch_if bus ();
    thread_dispatch dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Reference state, kept as plain integers.
    int          m_rr;
    int          m_flush [NUM_THREADS];
    int          m_tid   [NUM_ALUS];
    logic [31:0] m_inst  [NUM_ALUS];
    logic [3:0]  m_ack;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] pack3(input int a0, input int a1, input int a2);
        return {3'(a2), 3'(a1), 3'(a0)};
    endfunction

    // Advance the model by one clock using the inputs currently on the bus.
    task automatic model_update();
        bit hit [NUM_THREADS];
        bit el  [NUM_THREADS];
        int picks [$];
        for (int t = 0; t < NUM_THREADS; t++) hit[t] = 1'b0;
        for (int k = 0; k < NUM_ALUS; k++)
            if (bus.jump_en_i[k] && int'(bus.jump_tid_i[k]) < NUM_THREADS)
                hit[int'(bus.jump_tid_i[k])] = 1'b1;
        if (rst) begin
            m_rr = 0;
            m_ack = 4'b0;
            for (int t = 0; t < NUM_THREADS; t++) m_flush[t] = 0;
            for (int s = 0; s < NUM_ALUS; s++) begin
                m_tid[s] = 4; m_inst[s] = NOP_INST;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++)
                el[t] = bus.thread_valid_i[t] && !bus.thread_stall_i[t]
                        && m_flush[t] == 0 && !hit[t];
            for (int t = 0; t < NUM_THREADS; t++)
                m_flush[t] = hit[t] ? 2 : (m_flush[t] > 0 ? m_flush[t] - 1 : 0);
            if (bus.ex_ready_i) begin
                for (int i = 0; i < NUM_THREADS; i++) begin
                    int t;
                    t = (m_rr + i) % NUM_THREADS;
                    if (el[t] && picks.size() < NUM_ALUS) picks.push_back(t);
                end
                m_ack = 4'b0;
                for (int s = 0; s < NUM_ALUS; s++) begin
                    if (s < picks.size()) begin
                        m_tid[s]  = picks[s];
                        m_inst[s] = bus.thread_inst_i[picks[s]];
                        m_ack[picks[s]] = 1'b1;
                    end else begin
                        m_tid[s]  = 4;
                        m_inst[s] = NOP_INST;
                    end
                end
                if (picks.size() > 0) m_rr = (picks[$] + 1) % NUM_THREADS;
            end else begin
                m_ack = 4'b0;
            end
        end
    endtask

    task automatic compare();
        logic dup;
        logic nop_bad;
        dup = 1'b0;
        nop_bad = 1'b0;
        for (int s = 0; s < NUM_ALUS; s++) begin
            check($sformatf("slot%0d_tid", s), 64'(bus.dispatch_threads_o[s]), 64'(m_tid[s]));
            check($sformatf("slot%0d_inst", s), 64'(bus.dispatch_inst_o[s]), 64'(m_inst[s]));
            if (bus.dispatch_threads_o[s] >= 3'd4 && bus.dispatch_inst_o[s] !== NOP_INST) nop_bad = 1'b1;
            for (int s2 = s + 1; s2 < NUM_ALUS; s2++)
                if (bus.dispatch_threads_o[s] < 3'd4 && bus.dispatch_threads_o[s] === bus.dispatch_threads_o[s2])
                    dup = 1'b1;
        end
        check("issue_ack", 64'(bus.issue_ack_o), 64'(m_ack));
        check("no_dup_tid", 64'(dup), 64'(0));
        check("idle_is_nop", 64'(nop_bad), 64'(0));
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] st,
                         input logic rdy, input logic [2:0] jen, input logic [8:0] jtid);
        rst = r;
        bus.thread_valid_i = v;
        bus.thread_stall_i = st;
        bus.ex_ready_i     = rdy;
        bus.jump_en_i      = jen;
        bus.jump_tid_i     = jtid;
        for (int t = 0; t < NUM_THREADS; t++) bus.thread_inst_i[t] = $urandom;
        model_update();
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        bus.thread_valid_i = '0;
        bus.thread_stall_i = '0;
        bus.ex_ready_i     = 1'b0;
        bus.jump_en_i      = '0;
        bus.jump_tid_i     = '0;
        bus.thread_inst_i  = '0;

        // Reset state.
        drive(1'b1, 4'h0, 4'h0, 1'b1, 3'b0, 9'd0);
        drive(1'b1, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("rst_tids", 64'(bus.dispatch_threads_o), 64'(pack3(4, 4, 4)));
        check("rst_ack", 64'(bus.issue_ack_o), 64'(0));

        // All threads ready: two bundles from rr 0.
        drive(1'b0, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("all_c1_tids", 64'(bus.dispatch_threads_o), 64'(pack3(0, 1, 2)));
        check("all_c1_ack", 64'(bus.issue_ack_o), 64'(4'b0111));
        drive(1'b0, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("all_c2_tids", 64'(bus.dispatch_threads_o), 64'(pack3(3, 0, 1)));
        check("all_c2_ack", 64'(bus.issue_ack_o), 64'(4'b1011));

        // Only thread 2 valid.
        drive(1'b0, 4'b0100, 4'h0, 1'b1, 3'b0, 9'd0);
        check("one_tids", 64'(bus.dispatch_threads_o), 64'(pack3(2, 4, 4)));
        check("one_ack", 64'(bus.issue_ack_o), 64'(4'b0100));

        // Taken jump for thread 1 in EX slot 1: blocked this cycle and the next two.
        drive(1'b0, 4'hF, 4'h0, 1'b1, 3'b010, {3'd0, 3'd1, 3'd0});
        check("jmp_c0_ack1", 64'(bus.issue_ack_o[1]), 64'(0));
        drive(1'b0, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("jmp_c1_ack1", 64'(bus.issue_ack_o[1]), 64'(0));
        drive(1'b0, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("jmp_c2_ack1", 64'(bus.issue_ack_o[1]), 64'(0));
        drive(1'b0, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("jmp_c3_tids", 64'(bus.dispatch_threads_o), 64'(pack3(3, 0, 1)));

        // EX back-pressure for three cycles: outputs frozen, no acks, pointer held.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'hF, 4'h0, 1'b0, 3'b0, 9'd0);
            check("hold_tids", 64'(bus.dispatch_threads_o), 64'(pack3(3, 0, 1)));
            check("hold_ack", 64'(bus.issue_ack_o), 64'(0));
        end
        drive(1'b0, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("resume_tids", 64'(bus.dispatch_threads_o), 64'(pack3(2, 3, 0)));

        // Mid-stream reset, then issue restarts at thread 0.
        drive(1'b1, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        drive(1'b1, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("mid_rst_tids", 64'(bus.dispatch_threads_o), 64'(pack3(4, 4, 4)));
        drive(1'b0, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("post_rst_tids", 64'(bus.dispatch_threads_o), 64'(pack3(0, 1, 2)));

        // Everything stalled: idle bundle, pointer unchanged.
        drive(1'b0, 4'hF, 4'hF, 1'b1, 3'b0, 9'd0);
        check("stall_tids", 64'(bus.dispatch_threads_o), 64'(pack3(4, 4, 4)));
        check("stall_ack", 64'(bus.issue_ack_o), 64'(0));
        drive(1'b0, 4'hF, 4'h0, 1'b1, 3'b0, 9'd0);
        check("after_stall_tids", 64'(bus.dispatch_threads_o), 64'(pack3(3, 0, 1)));

        // Randomized traffic, including jumps carrying out-of-range tids.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] jen;
            jen = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
            drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  4'($urandom), 4'($urandom) & 4'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  jen, 9'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/thread_dispatch.md
Name: thread_dispatch

Overview:
- Issue stage directly upstream of the EX stage in the 4-thread, 3-ALU core.
- Each cycle, selects up to NUM_ALUs ready threads round-robin and presents one instruction per ALU slot, tagged with its thread id.
- Unfilled slots carry IDLE_TID. Thread ids below NUM_THREADS are real issues; the perf counters depend on this.
- Blocks a thread for FLUSH_CYCLES cycles after EX reports a taken jump for that thread.

Parameters:
- NUM_THREADS, 4, hardware thread count.
- NUM_ALUs, 3, ALU slots issued per cycle.
- TID_W, 3, thread-id width; must hold IDLE_TID.
- IDLE_TID, 3'd4, id marking an empty slot.
- FLUSH_CYCLES, 2, ineligible cycles after a taken jump (1..7).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- thread_valid_i  in  [NUM_THREADS]  decoded instruction available for thread t.
- thread_inst_i  in  [NUM_THREADS][32]  that instruction.
- thread_stall_i  in  [NUM_THREADS]  hazard stall for thread t.
- ex_ready_i  in  1  EX accepts a new slot bundle this cycle.
- jump_en_i  in  [NUM_ALUs]  taken jump/branch in EX slot k.
- jump_tid_i  in  [NUM_ALUs][TID_W]  thread id of EX slot k.
- dispatch_threads_o  out  [NUM_ALUs][TID_W]  thread id per slot.
- dispatch_inst_o  out  [NUM_ALUs][32]  instruction per slot.
- issue_ack_o  out  [NUM_THREADS]  thread t issued this cycle; fetch advances.

Behaviour:
- Clocking: all outputs registered; one-cycle latency from selection to output.
- Reset (rst=1 at posedge):
  - dispatch_threads_o = IDLE_TID in every slot.
  - dispatch_inst_o = 32'h00000013 (NOP).
  - issue_ack_o = 0.
  - rr_ptr = 0; all flush counters = 0.
  - Reset mid-operation discards in-flight selections; outputs go idle the following cycle.
- Flush counters:
  - For each k with jump_en_i[k]=1 and jump_tid_i[k]<NUM_THREADS, flush_cnt[jump_tid_i[k]] loads FLUSH_CYCLES.
  - Otherwise a nonzero flush_cnt decrements by 1 per cycle. It decrements regardless of ex_ready_i.
  - Several slots reporting the same tid reload once; no accumulation.
- Eligibility: elig[t] = thread_valid_i[t] & ~thread_stall_i[t] & (flush_cnt[t]==0) & ~jump_hit[t].
  - jump_hit[t] = any jump_en_i[k] with jump_tid_i[k]==t in the current cycle, so a jump blocks same-cycle issue.
- Selection:
  - Scan t = rr_ptr, rr_ptr+1, ... mod NUM_THREADS over one full wrap.
  - Assign eligible threads to slots 0,1,2 in scan order.
  - Each thread is granted at most once per cycle.
  - Remaining slots get IDLE_TID with the NOP instruction.
- Round-robin pointer:
  - After any grant, rr_ptr = (last granted tid + 1) mod NUM_THREADS.
  - With zero grants, rr_ptr is unchanged.
- EX not ready (ex_ready_i=0):
  - Registered slot outputs hold their values.
  - issue_ack_o = 0.
  - rr_ptr holds; no new selection commits.
- issue_ack_o[t] = 1 exactly in cycles where t occupies some slot of a newly committed bundle.
- Invariants:
  - No duplicate real tid across slots in one cycle.
  - A slot tid >= NUM_THREADS always carries the NOP instruction.

Decomposition:
- Package `types` holds NUM_THREADS, NUM_ALUs, TID_W, IDLE_TID, and NOP_INST=32'h00000013.
- It also holds the typedef `dispatch_slot_t` {tid, inst}, shared with the EX stage.
- One combinational sub-module, `rr_multi_pick`: inputs elig vector and rr_ptr; outputs per-slot tid, per-slot valid, and next rr_ptr. Reused by any future wider-issue variant.
- Flush counters, output registers and the ready hold live in thread_dispatch.

Test Plan:
1. rst=1 for 2 cycles mid-stream, then 0 → the cycle after reset, all slots tid=4 with inst 0x00000013, acks=0, then normal issue resumes from thread 0.
2. All 4 threads valid, no stall, rr_ptr=0 → slots {0,1,2}, ack=4'b0111, rr_ptr=3; next cycle slots {3,0,1}, ack=4'b1011, rr_ptr=2.
3. Only thread 2 valid → slot0=2 and slots1,2=4 with NOP; rr_ptr=3; ack=4'b0100.
4. jump_en_i[1]=1, jump_tid_i[1]=1, all valid → thread 1 not issued that cycle or the next 2; issuable on cycle 3.
5. ex_ready_i=0 for 3 cycles with all threads valid → outputs frozen, acks 0, rr_ptr unchanged; resumes from the same rr_ptr when ready returns.
6. All threads stalled → all slots tid=4, acks 0, rr_ptr unchanged; randomized run asserts no duplicate tids per cycle.
